// File: rtl/iprefetch_ctrl_pkg.sv
// Shared types and constants for the next-line instruction prefetch controller.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        HIT  = 2'd2,
        PF   = 2'd3
    } ipf_state_t;

    localparam int unsigned LINE_BYTES     = 32;
    localparam logic [31:0] IPF_WRAP_LIMIT = 32'hFFFF_FFE0;

endpackage

// File: rtl/iprefetch_ctrl_line_buffer.sv
// Single-entry prefetch line buffer: tag, data and valid with load/invalidate
// ports and a combinational tag compare against the current demand address.
module ipf_line_buffer
    import rv32i_types::*;
#(
    parameter int TAG_W = 27
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [TAG_W-1:0] load_tag,
    input  logic [255:0]     load_data,
    input  logic             inval,
    input  logic [TAG_W-1:0] lookup_tag,
    output logic             valid,
    output logic [TAG_W-1:0] tag,
    output logic [255:0]     data,
    output logic             match
);

    logic             valid_r;
    logic [TAG_W-1:0] tag_r;
    logic [255:0]     data_r;

    // Valid flag: invalidation wins over a load in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
        end else if (inval) begin
            valid_r <= 1'b0;
        end else if (load) begin
            valid_r <= 1'b1;
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag and data capture on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_r  <= {TAG_W{1'b0}};
            data_r <= 256'b0;
        end else if (load) begin
            tag_r  <= load_tag;
            data_r <= load_data;
        end else begin
            tag_r  <= tag_r;
            data_r <= data_r;
        end
    end

    assign valid = valid_r;
    assign tag   = tag_r;
    assign data  = data_r;
    assign match = valid_r && (tag_r == lookup_tag);

endmodule

// File: rtl/iprefetch_ctrl.sv
// Next-line instruction prefetch controller between icache fill port and arbiter port A.
// Prefetching is enabled by defining IPF_PREFETCH_EN; otherwise the block is a pass-through.
module iprefetch_ctrl
    import rv32i_types::*;
#(
    parameter int OFFSET_BITS = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         mem_read,
    input  logic         mem_write,
    input  logic [31:0]  mem_address,
    input  logic [255:0] mem_wdata,
    output logic         mem_resp,
    output logic [255:0] mem_rdata,
    output logic         pmem_read,
    output logic         pmem_write,
    output logic [31:0]  pmem_address,
    output logic [255:0] pmem_wdata,
    input  logic         pmem_resp,
    input  logic [255:0] pmem_rdata,
    output logic         pf_hit,
    output logic         pf_issue
);

    localparam int TAG_W = 32 - OFFSET_BITS;

    logic [31:0] demand_line_s;
    assign demand_line_s = {mem_address[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

`ifdef IPF_PREFETCH_EN

    ipf_state_t       state_r;
    ipf_state_t       state_next_s;
    logic [31:0]      pf_addr_r;
    logic [31:0]      pf_addr_next_s;
    logic             pf_first_r;
    logic             buf_load_s;
    logic             buf_inval_s;
    logic             buf_valid_s;
    logic             buf_match_s;
    logic [TAG_W-1:0] buf_tag_s;
    logic [255:0]     buf_data_s;
    logic [31:0]      buf_line_s;
    logic             unused_s;

    assign unused_s   = ^{buf_valid_s, mem_address[OFFSET_BITS-1:0]};
    assign buf_line_s = {buf_tag_s, {OFFSET_BITS{1'b0}}};

    ipf_line_buffer #(.TAG_W(TAG_W)) u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (buf_load_s),
        .load_tag   (pf_addr_r[31:OFFSET_BITS]),
        .load_data  (pmem_rdata),
        .inval      (buf_inval_s),
        .lookup_tag (mem_address[31:OFFSET_BITS]),
        .valid      (buf_valid_s),
        .tag        (buf_tag_s),
        .data       (buf_data_s),
        .match      (buf_match_s)
    );

    // State, prefetch address and first-PF-cycle flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            pf_addr_r  <= 32'h0;
            pf_first_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            pf_addr_r  <= pf_addr_next_s;
            pf_first_r <= (state_next_s == PF) && (state_r != PF);
        end
    end

    // Next state and all outputs; a prefetch past the top line is skipped by returning to IDLE.
    always_comb begin
        state_next_s   = state_r;
        pf_addr_next_s = pf_addr_r;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        pmem_address   = 32'h0;
        pmem_wdata     = 256'b0;
        mem_resp       = 1'b0;
        mem_rdata      = 256'b0;
        pf_hit         = 1'b0;
        pf_issue       = 1'b0;
        buf_load_s     = 1'b0;
        buf_inval_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (mem_read) begin
                    state_next_s = buf_match_s ? HIT : FWD;
                end else if (mem_write) begin
                    state_next_s = FWD;
                    buf_inval_s  = buf_match_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            FWD: begin
                pmem_read    = mem_read;
                pmem_write   = mem_write && !mem_read;
                pmem_address = demand_line_s;
                pmem_wdata   = mem_wdata;
                if (pmem_resp) begin
                    mem_resp  = 1'b1;
                    mem_rdata = pmem_rdata;
                    if (mem_read) begin
                        pf_addr_next_s = demand_line_s + 32'(LINE_BYTES);
                        state_next_s   = (demand_line_s >= IPF_WRAP_LIMIT) ? IDLE : PF;
                    end else begin
                        state_next_s = IDLE;
                    end
                end else begin
                    state_next_s = FWD;
                end
            end
            HIT: begin
                mem_resp       = 1'b1;
                mem_rdata      = buf_data_s;
                pf_hit         = 1'b1;
                buf_inval_s    = 1'b1;
                pf_addr_next_s = buf_line_s + 32'(LINE_BYTES);
                state_next_s   = (buf_line_s >= IPF_WRAP_LIMIT) ? IDLE : PF;
            end
            PF: begin
                pmem_read    = 1'b1;
                pmem_address = pf_addr_r;
                pf_issue     = pf_first_r;
                if (pmem_resp) begin
                    buf_load_s   = 1'b1;
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PF;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

`else

    logic unused_s;
    assign unused_s = ^{clk, rst_n, mem_address[OFFSET_BITS-1:0]};

    assign pmem_read    = mem_read;
    assign pmem_write   = mem_write;
    assign pmem_address = demand_line_s;
    assign pmem_wdata   = mem_wdata;
    assign mem_resp     = pmem_resp;
    assign mem_rdata    = pmem_rdata;
    assign pf_hit       = 1'b0;
    assign pf_issue     = 1'b0;

`endif

endmodule

// File: tb/tb_iprefetch_ctrl.sv
// Scoreboard bench for iprefetch_ctrl with a delayed-response arbiter model.
// Exercises the prefetching build when IPF_PREFETCH_EN is defined, pass-through otherwise.
module tb_iprefetch_ctrl;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         mem_read = 1'b0;
    logic         mem_write = 1'b0;
    logic [31:0]  mem_address = 32'h0;
    logic [255:0] mem_wdata = 256'b0;
    logic         mem_resp;
    logic [255:0] mem_rdata;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic         pmem_resp = 1'b0;
    logic [255:0] pmem_rdata = 256'b0;
    logic         pf_hit;
    logic         pf_issue;

    iprefetch_ctrl #(.OFFSET_BITS(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_resp     (mem_resp),
        .mem_rdata    (mem_rdata),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_resp    (pmem_resp),
        .pmem_rdata   (pmem_rdata),
        .pf_hit       (pf_hit),
        .pf_issue     (pf_issue)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic         we;
        logic [31:0]  addr;
        logic [255:0] wd;
    } pmem_exp_t;

    typedef struct {
        logic [255:0] data;
        logic         hit;
        logic         chk_data;
    } resp_exp_t;

    pmem_exp_t exp_pmem[$];
    resp_exp_t exp_resp[$];

    int errors = 0;
    int checks = 0;
    int arb_delay = 2;
    int arb_cnt = 0;
    logic arb_req = 1'b0;
    logic [31:0] arb_addr = 32'h0;
    int pf_issue_cnt = 0;
    int pf_hit_cnt = 0;
    int lat;

    task automatic check_value(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] line_data(input logic [31:0] a);
        logic [255:0] d;
        for (int i = 0; i < 8; i++) d[i*32 +: 32] = a ^ (32'h9E37_79B9 * (i + 1));
        return d;
    endfunction

    // Arbiter request sampling and response checking, away from the active edge.
    always @(negedge clk) begin
        arb_req  = (pmem_read || pmem_write) && !pmem_resp;
        arb_addr = pmem_address;
        if (pf_issue) pf_issue_cnt++;
        if (pf_hit) pf_hit_cnt++;
        if (pmem_resp) begin
            if (exp_pmem.size() == 0) begin
                check_value("pmem_unexpected", {pmem_write, pmem_read}, 2'b00);
            end else begin
                pmem_exp_t e;
                e = exp_pmem.pop_front();
                check_value("pmem_kind", {pmem_write, pmem_read}, e.we ? 2'b10 : 2'b01);
                check_value("pmem_addr", pmem_address, e.addr);
                if (e.we) check_value("pmem_wdata", pmem_wdata, e.wd);
            end
        end
        if (mem_resp) begin
            if (exp_resp.size() == 0) begin
                check_value("resp_unexpected", mem_resp, 1'b0);
            end else begin
                resp_exp_t r;
                r = exp_resp.pop_front();
                check_value("resp_hit", pf_hit, r.hit);
                if (r.chk_data) check_value("resp_data", mem_rdata, r.data);
            end
        end
    end

    // Arbiter model: responds arb_delay+1 cycles after a request is seen.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pmem_resp <= 1'b0;
            arb_cnt   <= 0;
        end else begin
            pmem_resp <= 1'b0;
            if (arb_req) begin
                if (arb_cnt >= arb_delay) begin
                    pmem_resp  <= 1'b1;
                    pmem_rdata <= line_data(arb_addr);
                    arb_cnt    <= 0;
                end else begin
                    arb_cnt <= arb_cnt + 1;
                end
            end
        end
    end

    task automatic push_pmem(input logic we, input logic [31:0] addr, input logic [255:0] wd);
        pmem_exp_t e;
        e.we = we; e.addr = addr; e.wd = wd;
        exp_pmem.push_back(e);
    endtask

    task automatic do_req(input logic we, input logic [31:0] addr, input logic [255:0] wd,
                          input logic [255:0] exp_data, input logic exp_hit, output int n);
        resp_exp_t r;
        r.data = exp_data; r.hit = exp_hit; r.chk_data = !we;
        exp_resp.push_back(r);
        @(posedge clk); #1;
        mem_read = !we; mem_write = we; mem_address = addr; mem_wdata = wd;
        n = 0;
        while (1) begin
            @(negedge clk);
            n++;
            if (mem_resp) break;
            if (n > 300) begin
                check_value("resp_timeout", 1'b0, 1'b1);
                void'(exp_resp.pop_front());
                break;
            end
        end
        @(posedge clk); #1;
        mem_read = 1'b0; mem_write = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_pmem.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (exp_pmem.size() != 0) check_value("drain_timeout", exp_pmem.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] wd;
        wd = {8{32'hC0DE_1234}};
        #1;
        check_value("rst_mem_resp", mem_resp, 1'b0);
        check_value("rst_pmem_read", pmem_read, 1'b0);
        check_value("rst_pmem_write", pmem_write, 1'b0);
        check_value("rst_pmem_addr", pmem_address, 32'h0);
        check_value("rst_pf", {pf_hit, pf_issue}, 2'b00);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_value("idle_no_pmem", {pmem_read, pmem_write, mem_resp}, 3'b000);
        end

`ifdef IPF_PREFETCH_EN
        // Cold miss, then next-line prefetch of 0x1020.
        push_pmem(1'b0, 32'h1000, 256'b0);
        push_pmem(1'b0, 32'h1020, 256'b0);
        do_req(1'b0, 32'h1000, 256'b0, line_data(32'h1000), 1'b0, lat);
        check_value("miss_lat", lat, arb_delay + 3);
        wait_drain();
        check_value("pf_cnt_cold", pf_issue_cnt, 1);

        // Hit on the buffered line, then prefetch 0x1040.
        push_pmem(1'b0, 32'h1040, 256'b0);
        do_req(1'b0, 32'h1024, 256'b0, line_data(32'h1020), 1'b1, lat);
        check_value("hit_lat", lat, 2);
        wait_drain();
        check_value("pf_cnt_hit", pf_issue_cnt, 2);

        // Write to the buffered line invalidates it; the following read misses.
        push_pmem(1'b1, 32'h1040, wd);
        do_req(1'b1, 32'h1040, wd, 256'b0, 1'b0, lat);
        repeat (3) @(negedge clk);
        check_value("no_pf_after_wr", pmem_read, 1'b0);
        check_value("pf_cnt_wr", pf_issue_cnt, 2);
        push_pmem(1'b0, 32'h1040, 256'b0);
        push_pmem(1'b0, 32'h1060, 256'b0);
        do_req(1'b0, 32'h1044, 256'b0, line_data(32'h1040), 1'b0, lat);
        check_value("inval_miss_lat", lat, arb_delay + 3);
        wait_drain();

        // Demand for the line being prefetched waits, then hits.
        arb_delay = 8;
        push_pmem(1'b0, 32'h2000, 256'b0);
        push_pmem(1'b0, 32'h2020, 256'b0);
        push_pmem(1'b0, 32'h2040, 256'b0);
        do_req(1'b0, 32'h2000, 256'b0, line_data(32'h2000), 1'b0, lat);
        do_req(1'b0, 32'h2020, 256'b0, line_data(32'h2020), 1'b1, lat);
        check_value("dmd_pf_lat", lat, arb_delay + 3);
        wait_drain();
        check_value("pf_cnt_dmd", pf_issue_cnt, 5);

        // Top line: served, no prefetch.
        arb_delay = 2;
        push_pmem(1'b0, 32'hFFFF_FFE0, 256'b0);
        do_req(1'b0, 32'hFFFF_FFE4, 256'b0, line_data(32'hFFFF_FFE0), 1'b0, lat);
        repeat (4) @(negedge clk);
        check_value("wrap_no_pf", pmem_read, 1'b0);
        check_value("pf_cnt_wrap", pf_issue_cnt, 5);

        // Reset during a prefetch drops it; the line then misses.
        arb_delay = 8;
        push_pmem(1'b0, 32'h3000, 256'b0);
        push_pmem(1'b0, 32'h3020, 256'b0);
        do_req(1'b0, 32'h3000, 256'b0, line_data(32'h3000), 1'b0, lat);
        @(negedge clk);
        @(negedge clk);
        check_value("pf_active", pmem_read, 1'b1);
        check_value("pf_active_addr", pmem_address, 32'h3020);
        #1 rst_n = 1'b0;
        #1 check_value("rst_drop", pmem_read, 1'b0);
        exp_pmem.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        arb_delay = 2;
        push_pmem(1'b0, 32'h3020, 256'b0);
        push_pmem(1'b0, 32'h3040, 256'b0);
        do_req(1'b0, 32'h3020, 256'b0, line_data(32'h3020), 1'b0, lat);
        check_value("post_rst_miss_lat", lat, arb_delay + 3);
        wait_drain();
        check_value("pf_hit_total", pf_hit_cnt, 2);
`else
        // Pass-through: every request goes to the arbiter, aligned.
        push_pmem(1'b0, 32'h1000, 256'b0);
        do_req(1'b0, 32'h1004, 256'b0, line_data(32'h1000), 1'b0, lat);
        check_value("pt_lat", lat, arb_delay + 2);
        push_pmem(1'b1, 32'h2000, wd);
        do_req(1'b1, 32'h2008, wd, 256'b0, 1'b0, lat);
        check_value("pt_wr_lat", lat, arb_delay + 2);
        push_pmem(1'b0, 32'h1000, 256'b0);
        do_req(1'b0, 32'h1004, 256'b0, line_data(32'h1000), 1'b0, lat);
        check_value("pt_no_buffer_lat", lat, arb_delay + 2);
        arb_delay = 8;
        push_pmem(1'b0, 32'hFFFF_FFE0, 256'b0);
        do_req(1'b0, 32'hFFFF_FFFC, 256'b0, line_data(32'hFFFF_FFE0), 1'b0, lat);
        check_value("pt_slow_lat", lat, arb_delay + 2);
        repeat (4) @(negedge clk);
        check_value("pt_idle", {pmem_read, pmem_write}, 2'b00);
        check_value("pt_pf_issue", pf_issue_cnt, 0);
        check_value("pt_pf_hit", pf_hit_cnt, 0);
`endif

        check_value("resp_queue_empty", exp_resp.size(), 0);
        check_value("pmem_queue_empty", exp_pmem.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
